alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Sequential, parametrised successor to the combinational WIDTH-bit ALU.
//  Same 8 base ops and 3 compare flags, plus a multi-cycle shift-add multiplier (low/high word).
//  Operands enter via a valid/ready handshake; results and flags leave through a registered
//  valid/ready output stage, so the block can sit between pipeline stages or an MMIO front end.
// PARAMETERS
//  WIDTH  4                  operand/result width in bits (>=2)
//  SHW    $clog2(WIDTH)      shift-amount width; derived, not overridden
// PORTS
//  clk        in   1      single clock, rising edge
//  rstn       in   1      asynchronous, active-low reset
//  in_valid   in   1      a/b/f valid this cycle
//  in_ready   out  1      block accepts an operation this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (b[SHW-1:0] is the shift amount for shifts)
//  f          in   4      opcode
//  out_valid  out  1      y/t hold a result
//  out_ready  in   1      consumer takes the result this cycle
//  y          out  WIDTH  result
//  t          out  3      flags: t[0] a==b, t[1] signed a<b, t[2] unsigned a<b
//  busy       out  1      multiplier iterating
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, out_valid=0, y=0, t=0, busy=0; internal regs cleared.
//  Opcodes: 0000 a-b | 0001 a+b | 0010 a&b | 0011 a|b | 0100 a^b | 0101 a>>sh (logical)
//   | 0110 a<<sh | 0111 a>>>sh (arith) | 1000 MUL low WIDTH bits of a*b (unsigned)
//   | 1001 MULHU high WIDTH bits of a*b | 1010-1111 reserved: y=0, flags valid, single-cycle.
//  Add/sub wrap modulo 2^WIDTH; no carry/overflow output. Shifts use b[SHW-1:0] only.
//  Flags are always computed from the accepted a,b regardless of opcode.
//  Accept: transfer when in_valid && in_ready on a rising edge; a,b,f captured.
//  in_ready = (state==IDLE) && (!out_valid || out_ready) -- no accept while multiplying,
//   or while a result is stalled; an accept in the same cycle as an output pop is allowed.
//  FSM: IDLE -> (accept, f=1000/1001) MUL; IDLE -> (accept, other f) IDLE with result loaded.
//   MUL: one shift-add step per cycle, counter 0..WIDTH-1, busy=1; after step WIDTH-1 load
//   y (low or high half of 2*WIDTH product), out_valid<=1, -> IDLE.
//  Latency: single-cycle ops: out_valid=1 the cycle after the accepting edge.
//   MUL/MULHU: out_valid=1 WIDTH+1 cycles after the accepting edge.
//  Output: y/t/out_valid held stable while out_valid && !out_ready. Pop clears out_valid
//   unless a new single-cycle result loads on the same edge (then out_valid stays 1).
//  Input changes while !in_ready are ignored; in_valid need not be held after accept.
//  Reset asserted mid-multiply aborts it; no result is produced after rstn rises.
//  Multiplier counter wraps via FSM exit only; no back-to-back MUL overlap.
// TESTING (WIDTH=4, a=4'b1011, b=4'b1100, out_ready=1 unless stated)
//  1 f=0000 -> next cycle out_valid=1, y=4'b1111, t=3'b110; f=0001 -> y=4'b0111, t=3'b110.
//  2 Sweep f=0010..0111 -> y=1000,1111,0111,1011>>0=1011,1011,1011 (sh=b[1:0]=0); then
//    b=4'b0001: 0101->0101, 0110->0110, 0111->1101.
//  3 f=1000 -> busy=1 for 4 cycles, out_valid 5 cycles after accept, y=4'b0100;
//    f=1001 -> y=4'b1000; in_ready=0 throughout.
//  4 out_ready=0 after a result: y/t held, in_ready=0 for 10 cycles; raise out_ready with
//    in_valid=1 f=0001 -> pop and accept same edge, next result y=4'b0111 next cycle.
//  5 rstn pulsed low during MUL cycle 2 -> immediately out_valid=0, y=0, busy=0; no late result.
//  6 Back-to-back single-cycle ops with in_valid=1 every cycle -> one result per cycle, in order.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential WIDTH-bit ALU with a valid/ready operand input, a registered
// valid/ready result output and a multi-cycle shift-add multiplier.
//
// Ports
//   clk        in   1      rising-edge clock
//   rstn       in   1      asynchronous active-low reset
//   in_valid   in   1      a/b/f valid this cycle
//   in_ready   out  1      operation accepted this cycle when in_valid is also high
//   a, b       in   WIDTH  operands (b[SHW-1:0] is the shift amount)
//   f          in   4      opcode
//   out_valid  out  1      y/t hold a result
//   out_ready  in   1      consumer takes the result this cycle
//   y          out  WIDTH  result
//   t          out  3      flags: t[0] a==b, t[1] signed a<b, t[2] unsigned a<b
//   busy       out  1      multiplier iterating
//
// state | meaning
// IDLE  | waiting for an operation; single-cycle ops load the result directly
// MUL   | one shift-add step per cycle, WIDTH steps, then load low/high half

module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       t,
    output logic             busy
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               hi_q;
    logic [2:0]         flags_q;
    logic [SHW-1:0]     cnt_q;

    logic               accept;
    logic               pop;
    logic               is_mul_op;
    logic               mul_last;
    logic               load_res;
    logic [WIDTH-1:0]   alu_y;
    logic [WIDTH-1:0]   res_nxt;
    logic [2:0]         flags_in;
    logic [2:0]         t_nxt;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_step;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign is_mul_op = (f == 4'b1000) || (f == 4'b1001);
    assign busy      = (state == MUL);
    assign mul_last  = (state == MUL) && (cnt_q == SHW'(WIDTH - 1));
    assign sh        = b[SHW-1:0];

    assign flags_in = {(a < b), ($signed(a) < $signed(b)), (a == b)};

    always_comb begin
        alu_y = '0;
        case (f)
            4'b0000: alu_y = a - b;
            4'b0001: alu_y = a + b;
            4'b0010: alu_y = a & b;
            4'b0011: alu_y = a | b;
            4'b0100: alu_y = a ^ b;
            4'b0101: alu_y = a >> sh;
            4'b0110: alu_y = a << sh;
            4'b0111: alu_y = $unsigned($signed(a) >>> sh);
            default: alu_y = '0;
        endcase
    end

    // Upper half accumulates the multiplicand, lower half holds the remaining
    // multiplier bits; each step shifts the pair right by one, carry included.
    assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
    assign prod_step = {step_sum, prod_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_res  = 1'b0;
        res_nxt   = '0;
        t_nxt     = flags_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul_op) begin
                        state_nxt = MUL;
                    end else begin
                        load_res = 1'b1;
                        res_nxt  = alu_y;
                        t_nxt    = flags_in;
                    end
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_nxt = IDLE;
                    load_res  = 1'b1;
                    res_nxt   = hi_q ? prod_step[2*WIDTH-1:WIDTH] : prod_step[WIDTH-1:0];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcand_q <= '0;
            prod_q  <= '0;
            hi_q    <= 1'b0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else if (accept && is_mul_op) begin
            mcand_q <= a;
            prod_q  <= {{WIDTH{1'b0}}, b};
            hi_q    <= f[0];
            flags_q <= flags_in;
            cnt_q   <= '0;
        end else if (state == MUL) begin
            prod_q <= prod_step;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // A fresh result wins over a pop on the same edge, so out_valid stays high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            y         <= '0;
            t         <= '0;
        end else if (load_res) begin
            out_valid <= 1'b1;
            y         <= res_nxt;
            t         <= t_nxt;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq (WIDTH=4) against a
// transaction-level reference model (pending-latency countdown plus integer maths).

module tb_alu_seq;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   f;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [2:0]   t;
    logic         busy;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    int m_ov   = 0;
    int m_y    = 0;
    int m_t    = 0;
    int m_pend = 0;
    int p_y    = 0;
    int p_t    = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .t         (t),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_y(input int av, input int bv, input int fv);
        int sh;
        int sa;
        int r;
        sh = bv % W;
        sa = (av >= M / 2) ? av - M : av;
        case (fv)
            0: return (av - bv + M) % M;
            1: return (av + bv) % M;
            2: return av & bv;
            3: return av | bv;
            4: return av ^ bv;
            5: return av / (1 << sh);
            6: return (av * (1 << sh)) % M;
            7: begin
                r = sa / (1 << sh);
                if (sa < 0 && (sa % (1 << sh)) != 0) r = r - 1;
                return (r + M) % M;
            end
            8: return (av * bv) % M;
            9: return (av * bv) / M;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_t(input int av, input int bv);
        int sa;
        int sb;
        sa = (av >= M / 2) ? av - M : av;
        sb = (bv >= M / 2) ? bv - M : bv;
        return ((av == bv) ? 1 : 0) + ((sa < sb) ? 2 : 0) + ((av < bv) ? 4 : 0);
    endfunction

    // Drive one cycle's inputs, check outputs against the model, then advance
    // the model across the coming rising edge.
    task automatic cycle(input logic iv, input logic ordy, input int ai, input int bi, input int fi);
        int m_rdy;
        int acc;
        int pop;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        a         = W'(ai);
        b         = W'(bi);
        f         = 4'(fi);
        #1;
        m_rdy = (m_pend == 0 && (m_ov == 0 || ordy)) ? 1 : 0;
        chk_val("out_valid", int'(out_valid), m_ov);
        chk_val("busy", int'(busy), (m_pend > 0) ? 1 : 0);
        chk_val("in_ready", int'(in_ready), m_rdy);
        if (m_ov != 0) begin
            chk_val("y", int'(y), m_y);
            chk_val("t", int'(t), m_t);
        end
        acc = (iv && m_rdy != 0) ? 1 : 0;
        pop = (m_ov != 0 && ordy) ? 1 : 0;
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                m_ov = 1;
                m_y  = p_y;
                m_t  = p_t;
            end
        end else if (acc != 0) begin
            if (fi == 8 || fi == 9) begin
                m_pend = W;
                p_y    = ref_y(ai, bi, fi);
                p_t    = ref_t(ai, bi);
                if (pop != 0) m_ov = 0;
            end else begin
                m_ov = 1;
                m_y  = ref_y(ai, bi, fi);
                m_t  = ref_t(ai, bi);
            end
        end else if (pop != 0) begin
            m_ov = 0;
        end
    endtask

    task automatic model_clear();
        m_ov   = 0;
        m_y    = 0;
        m_t    = 0;
        m_pend = 0;
    endtask

    task automatic run_mul(input int fi, input int exp_y);
        int busy_cnt;
        int lat;
        busy_cnt = 0;
        lat      = -1;
        cycle(1'b1, 1'b1, 4'b1011, 4'b1100, fi);
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            cycle((k <= 4), 1'b1, 0, k, 1);
            if (busy) busy_cnt++;
            if (out_valid) begin
                lat = k;
                chk_val("mul_y", int'(y), exp_y);
                chk_val("mul_t", int'(t), 3'b110);
            end
        end
        chk_val("mul_latency", lat, W + 1);
        chk_val("mul_busy_cycles", busy_cnt, W);
    endtask

    int sweep_f [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 5, 6, 7};
    int sweep_b [11] = '{12, 12, 12, 12, 12, 12, 12, 12, 1, 1, 1};
    int sweep_y [11] = '{15, 7, 8, 15, 7, 11, 11, 11, 5, 6, 13};
    int sweep_t [11] = '{6, 6, 6, 6, 6, 6, 6, 6, 2, 2, 2};

    initial begin
        int late;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        f         = '0;
        #2;
        chk_val("rst_out_valid", int'(out_valid), 0);
        chk_val("rst_y", int'(y), 0);
        chk_val("rst_t", int'(t), 0);
        chk_val("rst_busy", int'(busy), 0);
        chk_val("rst_in_ready", int'(in_ready), 1);
        #5;
        rstn = 1'b1;

        // opcode sweep, back-to-back accepts, one result per cycle in order
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, 1'b1, 4'b1011, sweep_b[i], sweep_f[i]);
            if (i > 0) begin
                chk_val("sweep_y", int'(y), sweep_y[i-1]);
                chk_val("sweep_t", int'(t), sweep_t[i-1]);
            end
        end
        cycle(1'b1, 1'b1, 4'b1011, 4'b1100, 4'b1010);
        chk_val("sweep_y_last", int'(y), sweep_y[10]);
        cycle(1'b0, 1'b1, 0, 0, 0);
        chk_val("reserved_y", int'(y), 0);
        chk_val("reserved_t", int'(t), 3'b110);
        cycle(1'b0, 1'b1, 0, 0, 0);

        // multiplier low/high
        run_mul(8, 4'b0100);
        run_mul(9, 4'b1000);

        // output stall, then pop and accept on the same edge
        cycle(1'b1, 1'b1, 4'b1011, 4'b1100, 0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b0, k, 3, 1);
            chk_val("stall_y", int'(y), 4'b1111);
            chk_val("stall_in_ready", int'(in_ready), 0);
        end
        cycle(1'b1, 1'b1, 4'b1011, 4'b1100, 1);
        cycle(1'b0, 1'b1, 0, 0, 0);
        chk_val("pop_accept_valid", int'(out_valid), 1);
        chk_val("pop_accept_y", int'(y), 4'b0111);

        // reset during multiply
        cycle(1'b1, 1'b1, 4'b1011, 4'b1100, 8);
        cycle(1'b0, 1'b1, 0, 0, 0);
        cycle(1'b0, 1'b1, 0, 0, 0);
        rstn = 1'b0;
        #1;
        chk_val("midrst_out_valid", int'(out_valid), 0);
        chk_val("midrst_y", int'(y), 0);
        chk_val("midrst_busy", int'(busy), 0);
        model_clear();
        #1;
        rstn = 1'b1;
        late = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 0, 0, 0);
            if (out_valid) late++;
        end
        chk_val("midrst_no_late_result", late, 0);

        // random traffic with backpressure
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
                  $urandom_range(0, M - 1), $urandom_range(0, M - 1), $urandom_range(0, 15));
        end
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
